// File: rtl/bin2bcd_seq_pkg.sv
// Shared state encodings and BCD adjust constants for the sequential
// binary-to-BCD converter.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= BCD_ADJ_THRESH) begin
            res = digit + BCD_ADJ_ADD;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Per-digit double-dabble correction: digits of 5 or more get 3 added so the
// following left shift carries correctly into the next decimal digit.
import bin2bcd_seq_pkg::*;

module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = bcd_adjust(digit_i);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes and a sticky overflow flag.
import bin2bcd_seq_pkg::*;

module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_ovf,
    output logic                busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [BW-1:0]    adj_s;
    logic [BW:0]      shifted_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // Top bit is what leaves the most significant digit and feeds overflow.
    assign shifted_s = {adj_s, bin_q[WIDTH-1]};

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SHIFT;
                    bin_d   = in_bin;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bin_d = bin_q << 1'b1;
                bcd_d = shifted_s[BW-1:0];
                ovf_d = ovf_q | shifted_s[BW];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT);
    assign out_valid = (state_q == ST_DONE);
    assign out_bcd   = bcd_q;
    assign out_ovf   = ovf_q;

endmodule
